mux_sel_sequencer: RTL and testbench
====================================

Name: mux_sel_sequencer

Overview:
Sequences the select line of one or more hard 2:1 muxes so that a source change never occurs while traffic is in flight. On a switch request it asks both sources to quiesce, waits for them to drain, and gates the mux output for a guard window. It flips the select in the middle of that window, then releases the sources and acknowledges. The block sits beside the hard mux cells: o_sel drives their select input, and o_gate drives the downstream output-qualify logic.

Parameters:
GUARD_CYCLES, 4, cycles of gated hold before and after the select flip; legal range 1..255
TIMEOUT_CYCLES, 0, maximum DRAIN cycles before aborting; 0 disables timeout; legal range 0..65535
RESET_SEL, 1'b0, value of o_sel after reset

Ports:
i_clk  input  1  block clock
i_rst  input  1  reset; asynchronous, active-high
i_req  input  1  switch request, sampled only in IDLE
i_req_sel  input  1  requested select value, sampled with i_req
i_idle0  input  1  source on mux input 0 has no transfer in flight
i_idle1  input  1  source on mux input 1 has no transfer in flight
o_sel  output  1  mux select; 0 selects input 0, 1 selects input 1
o_quiesce  output  1  request to both sources to stop issuing new transfers
o_gate  output  1  high while the mux output must be treated as invalid
o_busy  output  1  high whenever the sequencer is not in IDLE
o_ack  output  1  one-cycle pulse: request completed, or already satisfied
o_err  output  1  one-cycle pulse: drain timed out; select unchanged

Behaviour:
- Reset values: o_sel=RESET_SEL; o_quiesce, o_gate, o_busy, o_ack and o_err are all 0; state is IDLE; counters are 0.
- All outputs are registered. Reset takes effect asynchronously at any time, including mid-sequence, and o_sel returns to RESET_SEL.
- States: IDLE, DRAIN, GUARD_PRE, GUARD_POST.
- IDLE, i_req=1 and i_req_sel==o_sel:
  - o_ack=1 on the following cycle; state stays IDLE; no other output changes.
- IDLE, i_req=1 and i_req_sel!=o_sel:
  - latch the target; go to DRAIN.
  - o_quiesce=1 and o_busy=1 from the following cycle.
  - clear the timeout counter.
- i_req while o_busy=1 is ignored; there is no queue. Requesters wait for o_ack or o_err.
- DRAIN:
  - Each cycle, if i_idle0 & i_idle1 are both 1 in the same cycle: go to GUARD_PRE, set o_gate=1, load the guard counter with GUARD_CYCLES.
  - Otherwise increment the timeout counter.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES: o_err pulse; o_quiesce, o_busy and o_gate go to 0; go to IDLE; o_sel unchanged.
  - If idle and timeout occur in the same cycle, idle wins.
- GUARD_PRE:
  - Decrement the counter each cycle. The idle inputs are no longer monitored.
  - When the counter reaches 0: o_sel<=target, reload the counter with GUARD_CYCLES, go to GUARD_POST.
- GUARD_POST:
  - Decrement the counter each cycle.
  - When it reaches 0: o_ack pulse; o_gate, o_quiesce and o_busy go to 0; go to IDLE.
- Latency, request sampled at edge k with both sources already idle:
  - o_quiesce rises after edge k.
  - o_gate rises after edge k+1.
  - o_sel flips after edge k+1+GUARD_CYCLES.
  - o_ack is high for the single cycle after edge k+1+2*GUARD_CYCLES.
  - o_gate and o_busy fall at that same edge.
- Timing invariants:
  - o_sel only changes while o_gate=1, and never in the first or last cycle of the gate window.
  - o_ack and o_err are never high together.
- Counter widths: the guard counter is 8 bits and the timeout counter is 16 bits. Neither wraps; the guard counter saturates at 0 and the timeout counter saturates at TIMEOUT_CYCLES.

Test Plan:
- Reset release, then i_req=1, i_req_sel=0 with RESET_SEL=0 -> o_ack high exactly one cycle later; o_busy, o_gate and o_quiesce stay 0; o_sel=0.
- GUARD_CYCLES=4, both sources idle, request i_req_sel=1 at edge k -> o_quiesce after k, o_gate after k+1, o_sel=1 after k+5, o_ack only in the cycle after k+9; o_gate=0 from k+9.
- i_idle1 held low for 20 cycles after the request, then high -> DRAIN lasts 20 cycles; the rest of the sequence matches the previous case shifted by 20; o_err stays 0 with TIMEOUT_CYCLES=0.
- TIMEOUT_CYCLES=8, i_idle0 held low -> o_err pulse 8 cycles into DRAIN; o_sel unchanged; o_quiesce and o_busy fall; a new request is accepted afterwards.
- A second i_req with the opposite target issued during GUARD_PRE -> ignored; only one o_ack; o_sel ends at the first target.
- i_rst asserted asynchronously mid-GUARD_POST with o_sel already flipped -> all outputs return to their reset values immediately, o_sel=RESET_SEL; after release, a normal switch completes.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// ---------------------------------------------------------------------------
// mux_sel_sequencer
//
// Sequences the select line of hard 2:1 mux cells so that the source never
// changes while a transfer is in flight. A switch request quiesces both
// sources, waits for them to drain, gates the mux output for a guard window,
// flips the select halfway through that window, then releases and acks.
//
// Ports:
//   i_clk       block clock
//   i_rst       asynchronous, active-high reset
//   i_req       switch request (sampled only while idle)
//   i_req_sel   requested select value, sampled with i_req
//   i_idle0     source on mux input 0 has nothing in flight
//   i_idle1     source on mux input 1 has nothing in flight
//   o_sel       mux select (0 -> input 0, 1 -> input 1)
//   o_quiesce   ask both sources to stop issuing new transfers
//   o_gate      mux output must be treated as invalid
//   o_busy      sequencer is not idle
//   o_ack       one-cycle pulse: request completed or already satisfied
//   o_err       one-cycle pulse: drain timed out, select unchanged
// ---------------------------------------------------------------------------
module mux_sel_sequencer #(
  parameter int unsigned GUARD_CYCLES   = 4,    // 1..255
  parameter int unsigned TIMEOUT_CYCLES = 0,    // 0 disables the drain timeout
  parameter logic        RESET_SEL      = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_req_sel,
  input  logic i_idle0,
  input  logic i_idle1,
  output logic o_sel,
  output logic o_quiesce,
  output logic o_gate,
  output logic o_busy,
  output logic o_ack,
  output logic o_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_GUARD_PRE,
    ST_GUARD_POST
  } state_t;

  localparam logic [7:0]  GUARD_LOAD  = 8'(GUARD_CYCLES);
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  // With the timeout disabled the counter just parks at its maximum.
  localparam logic [15:0] TIMEOUT_SAT = TIMEOUT_EN ? TIMEOUT_LIM : 16'hFFFF;

  state_t      state, state_n;
  logic        target, target_n;
  logic [7:0]  guard_cnt, guard_n;
  logic [15:0] to_cnt, to_n;
  logic        sel_n, quiesce_n, gate_n, busy_n, ack_n, err_n;

  // Saturating counter steps: guard stops at 0, timeout stops at its limit.
  logic [7:0]  guard_dec;
  logic [15:0] to_inc;
  assign guard_dec = (guard_cnt != 8'd0) ? guard_cnt - 8'd1 : 8'd0;
  assign to_inc    = (to_cnt == TIMEOUT_SAT) ? to_cnt : to_cnt + 16'd1;

  // NOTE: every register here is a handful of flops, so all of them, counters
  // and latched target included, get a reset value; nothing is left to X.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      target    <= RESET_SEL;
      guard_cnt <= 8'd0;
      to_cnt    <= 16'd0;
      o_sel     <= RESET_SEL;
      o_quiesce <= 1'b0;
      o_gate    <= 1'b0;
      o_busy    <= 1'b0;
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed below; blocking here would create ordering races.
      state     <= state_n;
      target    <= target_n;
      guard_cnt <= guard_n;
      to_cnt    <= to_n;
      o_sel     <= sel_n;
      o_quiesce <= quiesce_n;
      o_gate    <= gate_n;
      o_busy    <= busy_n;
      o_ack     <= ack_n;
      o_err     <= err_n;
    end
  end

  always_comb begin
    // NOTE: hold-current defaults on every output of this block first, so no
    // path through the case statement can leave a signal unassigned (latch).
    state_n   = state;
    target_n  = target;
    guard_n   = guard_cnt;
    to_n      = to_cnt;
    sel_n     = o_sel;
    quiesce_n = o_quiesce;
    gate_n    = o_gate;
    busy_n    = o_busy;
    ack_n     = 1'b0;
    err_n     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (i_req) begin
          if (i_req_sel == o_sel) begin
            ack_n = 1'b1;               // already on the requested input
          end else begin
            target_n  = i_req_sel;
            state_n   = ST_DRAIN;
            quiesce_n = 1'b1;
            busy_n    = 1'b1;
            to_n      = 16'd0;
          end
        end
      end

      ST_DRAIN: begin
        // Idle wins over a timeout landing in the same cycle.
        if (i_idle0 && i_idle1) begin
          state_n = ST_GUARD_PRE;
          gate_n  = 1'b1;
          guard_n = GUARD_LOAD;
        end else begin
          to_n = to_inc;
          if (TIMEOUT_EN && (to_inc == TIMEOUT_LIM)) begin
            err_n     = 1'b1;
            quiesce_n = 1'b0;
            busy_n    = 1'b0;
            gate_n    = 1'b0;
            state_n   = ST_IDLE;
          end
        end
      end

      ST_GUARD_PRE: begin
        guard_n = guard_dec;
        if (guard_dec == 8'd0) begin
          sel_n   = target;             // flip in the middle of the gate window
          guard_n = GUARD_LOAD;
          state_n = ST_GUARD_POST;
        end
      end

      ST_GUARD_POST: begin
        guard_n = guard_dec;
        if (guard_dec == 8'd0) begin
          ack_n     = 1'b1;
          gate_n    = 1'b0;
          quiesce_n = 1'b0;
          busy_n    = 1'b0;
          state_n   = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_sequencer
//
// Two instances share one stimulus stream: instance 0 (GUARD=4, no timeout,
// reset select 0) and instance 1 (GUARD=3, TIMEOUT=8, reset select 1).
// A timeline model predicts per-instance state from request/drain times and
// pushes expected ack/err pulses into a queue; a monitor pops and compares
// whenever a DUT pulses o_ack or o_err, and checks levels every cycle.
// ---------------------------------------------------------------------------
module tb_mux_sel_sequencer;

  localparam int   G0 = 4, T0 = 0;
  localparam logic RS0 = 1'b0;
  localparam int   G1 = 3, T1 = 8;
  localparam logic RS1 = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req, req_sel, idle0, idle1;
  logic [1:0] sel_w, quiesce_w, gate_w, busy_w, ack_w, err_w;

  always #5 clk = ~clk;

  mux_sel_sequencer #(.GUARD_CYCLES(G0), .TIMEOUT_CYCLES(T0), .RESET_SEL(RS0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_sel(req_sel),
    .i_idle0(idle0), .i_idle1(idle1),
    .o_sel(sel_w[0]), .o_quiesce(quiesce_w[0]), .o_gate(gate_w[0]),
    .o_busy(busy_w[0]), .o_ack(ack_w[0]), .o_err(err_w[0]));

  mux_sel_sequencer #(.GUARD_CYCLES(G1), .TIMEOUT_CYCLES(T1), .RESET_SEL(RS1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_sel(req_sel),
    .i_idle0(idle0), .i_idle1(idle1),
    .o_sel(sel_w[1]), .o_quiesce(quiesce_w[1]), .o_gate(gate_w[1]),
    .o_busy(busy_w[1]), .o_ack(ack_w[1]), .o_err(err_w[1]));

  function automatic int g_of(int i);  return (i == 0) ? G0 : G1;   endfunction
  function automatic int t_of(int i);  return (i == 0) ? T0 : T1;   endfunction
  function automatic logic rs_of(int i); return (i == 0) ? RS0 : RS1; endfunction

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (timeline based) ----------------
  typedef enum {R_ACK, R_ERR} resp_kind_t;
  typedef struct {
    int         inst;
    resp_kind_t kind;
    int         cyc;   // pulse is high in the cycle after this edge
    logic       sel;
  } resp_t;

  resp_t exp_q[$];
  int    cyc = 0;
  bit    rst_seen;
  bit    m_busy [2];
  bit    m_drained [2];
  logic  m_sel [2];
  logic  m_tgt [2];
  int    m_k [2];      // edge the switch request was accepted
  int    m_g [2];      // edge the drain completed (gate window opens)

  task automatic push(int i, resp_kind_t k, int c, logic s);
    resp_t r;
    r.inst = i; r.kind = k; r.cyc = c; r.sel = s;
    exp_q.push_back(r);
  endtask

  task automatic model_step(int i);
    int e = cyc;
    int g = g_of(i);
    int t = t_of(i);
    if (!m_busy[i]) begin
      if (req) begin
        if (req_sel == m_sel[i]) push(i, R_ACK, e, m_sel[i]);
        else begin
          m_busy[i] = 1'b1; m_drained[i] = 1'b0; m_k[i] = e; m_tgt[i] = req_sel;
        end
      end
    end else if (!m_drained[i]) begin
      if (idle0 && idle1) begin
        m_drained[i] = 1'b1; m_g[i] = e;
        push(i, R_ACK, e + 2 * g, m_tgt[i]);
      end else if (t != 0 && (e - m_k[i]) >= t) begin
        push(i, R_ERR, e, m_sel[i]);
        m_busy[i] = 1'b0;
      end
    end else begin
      if (e == m_g[i] + g) m_sel[i] = m_tgt[i];
      if (e == m_g[i] + 2 * g) begin m_busy[i] = 1'b0; m_drained[i] = 1'b0; end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0; m_drained[i] = 1'b0; m_sel[i] = rs_of(i);
      end
      exp_q.delete();
      rst_seen = 1'b1;
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // ---------------- monitor ----------------
  logic prev_sel [2];
  logic prev_gate [2];

  always @(negedge clk) begin
    int idx;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("sel%0d", i),     sel_w[i],     m_sel[i]);
        check($sformatf("quiesce%0d", i), quiesce_w[i], m_busy[i]);
        check($sformatf("busy%0d", i),    busy_w[i],    m_busy[i]);
        check($sformatf("gate%0d", i),    gate_w[i],    m_busy[i] & m_drained[i]);
        check($sformatf("ack_err_excl%0d", i), ack_w[i] & err_w[i], 0);
        if (!rst_seen && sel_w[i] != prev_sel[i])
          check($sformatf("sel_inside_gate%0d", i), prev_gate[i] & gate_w[i], 1);
        if (ack_w[i] | err_w[i]) begin
          idx = -1;
          for (int j = 0; j < exp_q.size(); j++)
            if (idx < 0 && exp_q[j].inst == i) idx = j;
          check($sformatf("resp_expected%0d", i), int'(idx >= 0), 1);
          if (idx >= 0) begin
            check($sformatf("resp_is_err%0d", i), err_w[i], int'(exp_q[idx].kind == R_ERR));
            check($sformatf("resp_cycle%0d", i), cyc, exp_q[idx].cyc);
            check($sformatf("resp_sel%0d", i), sel_w[i], exp_q[idx].sel);
            exp_q.delete(idx);
          end
        end
        prev_sel[i]  = sel_w[i];
        prev_gate[i] = gate_w[i];
      end
      // Anything due by now that the DUT did not present was missed.
      for (int j = exp_q.size() - 1; j >= 0; j--) begin
        if (exp_q[j].cyc <= cyc) begin
          check($sformatf("resp_seen%0d", exp_q[j].inst),
                ack_w[exp_q[j].inst] | err_w[exp_q[j].inst], 1);
          exp_q.delete(j);
        end
      end
      rst_seen = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_vals(string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_sel%0d", tag, i), sel_w[i], rs_of(i));
      check($sformatf("%s_outs%0d", tag, i),
            {quiesce_w[i], gate_w[i], busy_w[i], ack_w[i], err_w[i]}, 0);
    end
  endtask

  task automatic pulse_req(logic s);
    req = 1'b1; req_sel = s;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy_w != 2'b00 && n < budget) begin @(negedge clk); n++; end
    check("wait_idle", busy_w, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic tgt;
    int   n;
    req = 1'b0; req_sel = 1'b0; idle0 = 1'b1; idle1 = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_reset_vals("reset_hold");
    @(negedge clk); rst = 1'b0;
    #1 check_reset_vals("reset_release");

    // Already-satisfied request for instance 0; instance 1 switches 1->0.
    @(negedge clk);
    pulse_req(1'b0);
    wait_idle(50);

    // Switch to 1; opposite request during GUARD_PRE must be ignored.
    pulse_req(1'b1);
    repeat (2) @(negedge clk);
    pulse_req(1'b0);
    wait_idle(50);

    // Source 1 busy for 20 drain cycles; instance 0 has no timeout.
    idle1 = 1'b0;
    pulse_req(!m_sel[0]);
    repeat (19) @(negedge clk);
    idle1 = 1'b1;
    wait_idle(100);

    // Source 0 stuck: instance 1 times out, then accepts a new request.
    idle0 = 1'b0;
    pulse_req(!m_sel[1]);
    repeat (12) @(negedge clk);
    pulse_req(!m_sel[1]);
    repeat (12) @(negedge clk);
    idle0 = 1'b1;
    wait_idle(100);
    pulse_req(!m_sel[1]);
    wait_idle(100);

    // Asynchronous reset mid-GUARD_POST with the select already flipped.
    tgt = !m_sel[0];
    pulse_req(tgt);
    n = 0;
    while (!(sel_w[0] == tgt && gate_w[0]) && n < 50) begin @(negedge clk); n++; end
    check("reach_guard_post", sel_w[0], tgt);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    #1 check_reset_vals("reset_held");
    rst = 1'b0;
    @(negedge clk);
    pulse_req(!m_sel[0]);
    wait_idle(100);

    // Randomized traffic with periodic long stalls on source 0.
    for (int c = 0; c < 600; c++) begin
      idle0   = ((c % 100) < 14) ? 1'b0 : ($urandom_range(0, 9) != 0);
      idle1   = ($urandom_range(0, 9) != 0);
      req     = ($urandom_range(0, 3) == 0);
      req_sel = 1'($urandom);
      @(negedge clk);
    end
    req = 1'b0; idle0 = 1'b1; idle1 = 1'b1;
    wait_idle(100);
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
